// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source.
// Header byte layout is {len, addr}, matching the router's expected framing.
package router_pkg;
   localparam int ADDR_W  = 2;
   localparam int LEN_W   = 6;
   localparam int MAX_LEN = 63;

   localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HDR,
      ST_PLD,
      ST_PAR,
      ST_GAP
   } state_t;

   typedef struct packed {
      logic [LEN_W-1:0]  len;
      logic [ADDR_W-1:0] addr;
   } hdr_t;
endpackage

// File: rtl/router_tx_buf.sv
// Payload store: filled byte-by-byte while loading, drained in order while sending.
module router_tx_buf
   import router_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   input  logic             rd_adv,
   output logic [7:0]       rd_data,
   output logic [LEN_W-1:0] wr_ptr,
   output logic [LEN_W-1:0] rd_ptr
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
         if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/router_pkt_source.sv
// Buffers a whole payload from the host, then streams header/payload/parity into the router.
// Output byte and valid are registered so busy never reaches them combinationally.
module router_pkt_source
   import router_pkg::*;
#(
   parameter int MAX_LEN = 63,
   parameter int GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_vld,
   output logic              req_rdy,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              pld_vld,
   output logic              pld_rdy,
   input  logic [7:0]        pld_data,
   input  logic              busy,
   input  logic              err,
   output logic              pkt_vld,
   output logic [7:0]        d_out,
   output logic              done,
   output logic              pkt_err,
   output logic [15:0]       sent_cnt
);
   localparam int GW = $clog2(GAP_CYC + 1);

   state_t           state, state_nx;
   hdr_t             hdr_q;
   logic [7:0]       par_q;
   logic [GW-1:0]    gap_cnt;
   logic             err_acc, rej_q;
   logic             wr_en, rd_adv, last_gap, req_ok;
   logic [7:0]       rd_data;
   logic [LEN_W-1:0] wr_ptr, rd_ptr;

   assign req_ok = (req_addr != ADDR_ILLEGAL) && (req_len != '0);

   router_tx_buf #(.DEPTH(MAX_LEN + 1)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == ST_IDLE),
      .wr_en   (wr_en),
      .wr_data (pld_data),
      .rd_adv  (rd_adv),
      .rd_data (rd_data),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr)
   );

   always_comb begin
      state_nx = state;
      req_rdy  = 1'b0;
      pld_rdy  = 1'b0;
      wr_en    = 1'b0;
      rd_adv   = 1'b0;
      last_gap = 1'b0;
      case (state)
         ST_IDLE: begin
            req_rdy = !rst;
            if (req_vld && req_ok) state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            pld_rdy = 1'b1;
            if (pld_vld) begin
               wr_en = 1'b1;
               if (wr_ptr == hdr_q.len - 6'd1) state_nx = ST_HDR;
            end
         end
         ST_HDR: if (!busy) begin
            rd_adv   = 1'b1;
            state_nx = ST_PLD;
         end
         // rd_ptr is one ahead of the byte on d_out, so equality with len means the last byte is showing
         ST_PLD: if (!busy) begin
            if (rd_ptr == hdr_q.len) state_nx = ST_PAR;
            else                     rd_adv   = 1'b1;
         end
         ST_PAR: if (!busy) state_nx = ST_GAP;
         ST_GAP: if (gap_cnt == GW'(GAP_CYC - 1)) begin
            last_gap = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         hdr_q    <= '0;
         par_q    <= '0;
         gap_cnt  <= '0;
         err_acc  <= 1'b0;
         rej_q    <= 1'b0;
         pkt_vld  <= 1'b0;
         d_out    <= '0;
         sent_cnt <= '0;
      end else begin
         state <= state_nx;
         rej_q <= (state == ST_IDLE) && req_vld && !req_ok;
         case (state)
            ST_IDLE: begin
               err_acc <= 1'b0;
               if (req_vld && req_ok) begin
                  hdr_q <= '{len: req_len, addr: req_addr};
                  par_q <= {req_len, req_addr};
               end
            end
            ST_LOAD: if (wr_en) begin
               par_q <= par_q ^ pld_data;
               if (state_nx == ST_HDR) begin
                  pkt_vld <= 1'b1;
                  d_out   <= hdr_q;
               end
            end
            ST_HDR, ST_PLD: begin
               if (rd_adv) begin
                  d_out <= rd_data;
               end else if (state_nx == ST_PAR) begin
                  pkt_vld <= 1'b0;
                  d_out   <= par_q;
               end
            end
            ST_PAR: begin
               err_acc <= err_acc | err;
               gap_cnt <= '0;
            end
            ST_GAP: begin
               err_acc <= err_acc | err;
               gap_cnt <= gap_cnt + 1'b1;
               if (last_gap && !(err_acc || err)) sent_cnt <= sent_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign done    = rej_q | last_gap;
   assign pkt_err = rej_q | (last_gap & (err_acc | err));
endmodule

// File: tb/tb_router_pkt_source.sv
// Bench for router_pkt_source: packet-level reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_router_pkt_source;
   localparam int GAP_CYC = 2;

   logic        clk, rst;
   logic        req_vld, req_rdy, pld_vld, pld_rdy, busy, err;
   logic [1:0]  req_addr;
   logic [5:0]  req_len;
   logic [7:0]  pld_data, d_out;
   logic        pkt_vld, done, pkt_err;
   logic [15:0] sent_cnt;

   router_pkt_source #(.MAX_LEN(63), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_len(req_len),
      .pld_vld(pld_vld), .pld_rdy(pld_rdy), .pld_data(pld_data),
      .busy(busy), .err(err),
      .pkt_vld(pkt_vld), .d_out(d_out), .done(done), .pkt_err(pkt_err), .sent_cnt(sent_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   // ---------------- reference model (packet level) ----------------
   typedef struct { logic [7:0] b; logic v; } ob_t;
   ob_t        out_q[$];
   logic [7:0] pq[$];
   int         mode;        // 0 waiting for request, 1 collecting payload, 2 emitting
   int         gap_left, m_len;
   logic       err_seen, rej_pend;
   logic [7:0] m_hdr, m_par;
   logic [15:0] m_cnt;
   int         vld_cycles;
   logic [7:0] dut_par;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req_rdy", req_rdy, 0);
         chk("rst_pld_rdy", pld_rdy, 0);
         chk("rst_pkt_vld", pkt_vld, 0);
         chk("rst_d_out", d_out, 0);
         chk("rst_done", done, 0);
         chk("rst_pkt_err", pkt_err, 0);
         chk("rst_sent_cnt", sent_cnt, 0);
         mode = 0; gap_left = 0; err_seen = 0; rej_pend = 0; m_cnt = 0;
         out_q.delete(); pq.delete();
      end else begin
         chk("req_rdy", req_rdy, mode == 0);
         chk("pld_rdy", pld_rdy, mode == 1);
         chk("pkt_vld", pkt_vld, (out_q.size() > 0) ? out_q[0].v : 1'b0);
         if (out_q.size() > 0)  chk("d_out", d_out, out_q[0].b);
         else if (gap_left > 0) chk("d_out_gap", d_out, m_par);
         chk("done", done, rej_pend || gap_left == 1);
         chk("pkt_err", pkt_err, rej_pend || (gap_left == 1 && (err_seen || err)));
         chk("sent_cnt", sent_cnt, m_cnt);
         if (pkt_vld) vld_cycles++;
         if (out_q.size() > 0 && !out_q[0].v) dut_par = d_out;

         // advance to what the next edge will do
         rej_pend = 1'b0;
         case (mode)
            0: if (req_vld) begin
               if (req_addr == 2'd3 || req_len == 6'd0) rej_pend = 1'b1;
               else begin
                  mode = 1; m_len = req_len; m_hdr = {req_len, req_addr}; pq.delete();
               end
            end
            1: if (pld_vld) begin
               pq.push_back(pld_data);
               if (pq.size() == m_len) begin
                  logic [7:0] p;
                  p = m_hdr;
                  out_q.push_back('{m_hdr, 1'b1});
                  foreach (pq[i]) begin
                     out_q.push_back('{pq[i], 1'b1});
                     p ^= pq[i];
                  end
                  out_q.push_back('{p, 1'b0});
                  m_par = p;
                  mode = 2;
               end
            end
            default: begin
               if (out_q.size() > 0) begin
                  if (!out_q[0].v) err_seen |= err;
                  if (!busy) begin
                     if (!out_q[0].v) gap_left = GAP_CYC;
                     void'(out_q.pop_front());
                  end
               end else begin
                  err_seen |= err;
                  if (gap_left == 1) begin
                     if (!err_seen) m_cnt++;
                     err_seen = 1'b0;
                     mode = 0;
                  end
                  gap_left--;
               end
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [1:0] a, input logic [5:0] l);
      int t = 0;
      req_addr = a; req_len = l; req_vld = 1'b1;
      while (!req_rdy && t < 100) begin tick(); t++; end
      if (!req_rdy) timeout("req_hs");
      tick();
      req_vld = 1'b0;
   endtask

   task automatic send_pld(input int n, input logic [7:0] base, input int stall_at, input int stall_len);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         if (i == stall_at) begin
            pld_vld = 1'b0;
            err = 1'b1;                // ignored outside parity/gap
            repeat (stall_len) tick();
            err = 1'b0;
         end
         pld_vld = 1'b1;
         pld_data = base + 8'(i);
         while (!pld_rdy && t < 100) begin tick(); t++; end
         if (!pld_rdy) timeout("pld_hs");
         tick();
      end
      pld_vld = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while (!done && t < 300) begin tick(); t++; end
      if (!done) timeout(nm);
   endtask

   task automatic wait_vld(input logic lvl, input string nm);
      int t = 0;
      while (pkt_vld !== lvl && t < 300) begin tick(); t++; end
      if (pkt_vld !== lvl) timeout(nm);
   endtask

   initial begin
      rst = 1'b1; req_vld = 0; req_addr = 0; req_len = 0;
      pld_vld = 0; pld_data = 0; busy = 0; err = 0; vld_cycles = 0; dut_par = 0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // addr=2 len=14 payload 01..0E: header 3A, parity 3A^0F = 35
      vld_cycles = 0;
      do_req(2'd2, 6'd14);
      send_pld(14, 8'h01, -1, 0);
      wait_done("t1_done");
      chk("t1_pkt_err", pkt_err, 0);
      chk("t1_par", dut_par, 8'h35);
      chk("t1_vld_cycles", vld_cycles, 15);
      tick();
      chk("t1_sent_cnt", sent_cnt, 1);

      // addr=0 len=1 payload FF, busy 3 cycles on header: header 04 held 4 cycles, parity FB
      vld_cycles = 0;
      do_req(2'd0, 6'd1);
      send_pld(1, 8'hFF, -1, 0);
      wait_vld(1'b1, "t2_hdr");
      chk("t2_hdr", d_out, 8'h04);
      busy = 1'b1;
      repeat (3) tick();
      busy = 1'b0;
      wait_done("t2_done");
      chk("t2_par", dut_par, 8'hFB);
      chk("t2_vld_cycles", vld_cycles, 5);
      tick();
      chk("t2_sent_cnt", sent_cnt, 2);

      // illegal requests: rejected, nothing to the router
      vld_cycles = 0;
      do_req(2'd3, 6'd5);
      wait_done("t3a_done");
      chk("t3a_pkt_err", pkt_err, 1);
      tick();
      do_req(2'd1, 6'd0);
      wait_done("t3b_done");
      chk("t3b_pkt_err", pkt_err, 1);
      tick();
      chk("t3_vld_cycles", vld_cycles, 0);
      chk("t3_sent_cnt", sent_cnt, 2);

      // host stalls 5 cycles mid-load, err pulsed while loading is ignored
      vld_cycles = 0;
      do_req(2'd1, 6'd4);
      send_pld(4, 8'hA0, 2, 5);
      wait_done("t4_done");
      chk("t4_pkt_err", pkt_err, 0);
      chk("t4_vld_cycles", vld_cycles, 5);
      tick();
      chk("t4_sent_cnt", sent_cnt, 3);

      // err during first gap cycle
      do_req(2'd2, 6'd3);
      send_pld(3, 8'h50, -1, 0);
      wait_vld(1'b0, "t5_par");
      tick();
      err = 1'b1;
      tick();
      err = 1'b0;
      wait_done("t5_done");
      chk("t5_pkt_err", pkt_err, 1);
      tick();
      chk("t5_sent_cnt", sent_cnt, 3);

      // reset in the middle of a len=20 payload, then a fresh len=2 packet
      do_req(2'd1, 6'd20);
      send_pld(20, 8'h10, -1, 0);
      wait_vld(1'b1, "t6_hdr");
      repeat (5) tick();
      #2 rst = 1'b1;
      #1 chk("t6_async_vld", pkt_vld, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      vld_cycles = 0;
      do_req(2'd0, 6'd2);
      send_pld(2, 8'hC3, -1, 0);
      wait_done("t6_done");
      chk("t6_pkt_err", pkt_err, 0);
      chk("t6_vld_cycles", vld_cycles, 3);
      chk("t6_par", dut_par, 8'h08 ^ 8'hC3 ^ 8'hC4);
      tick();
      chk("t6_sent_cnt", sent_cnt, 1);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
